// File: rtl/mini_text_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mini_text_pkg
// Brief    : Shared types and constants for the HUD scanline text engine.
// Revision : 1.0 - initial release
// ============================================================================
package mini_text_pkg;

    typedef enum logic {IDLE, FETCH} mt_state_e;

    localparam logic [5:0] MT_BLANK   = 6'd63;
    localparam int         MT_GLYPH_W = 8;
    localparam int         MT_GLYPH_H = 8;

endpackage
`default_nettype wire

// File: rtl/mini_text_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mini_text_line_buffer
// Brief    : One fetched glyph row per character, with a bit-select read port.
// Revision : 1.0 - initial release
// ============================================================================
module mini_text_line_buffer #(
    parameter int NUM_CHARS = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_char,
    input  logic [2:0]       rd_bit,
    output logic             rd_out
);

    logic [NUM_CHARS*8-1:0] w_flat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHARS; gi++) begin : g_entry
            logic [7:0] r_row;

            // Clear wins so an aborted fetch never leaves a half-written line.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_row <= '0;
                end else if (clr) begin
                    r_row <= '0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    r_row <= wr_data;
                end
            end

            assign w_flat[gi*8 +: 8] = r_row;
        end
    endgenerate

    always_comb begin
        rd_out = 1'b0;
        if (32'(rd_char) < NUM_CHARS) begin
            rd_out = w_flat[{rd_char, rd_bit}];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mini_text_line_engine.sv
`default_nettype none
// ============================================================================
// Module   : mini_text_line_engine
// Brief    : Scanline text renderer; fetches glyph rows in hblank, lights pixels
//            in active video. Define MINI_TEXT_SHADOW_EN for frame-synced slots.
// Revision : 1.0 - initial release
// ============================================================================
module mini_text_line_engine
    import mini_text_pkg::*;
#(
    parameter int         NUM_CHARS   = 8,
    parameter logic [9:0] X_POS       = 10'd0,
    parameter logic [9:0] Y_POS       = 10'd0,
    parameter int         SCALE_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       line_start,
    input  logic [9:0] line_y,
    input  logic       de,
    input  logic [9:0] x_pixel,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [5:0] wr_data,
    output logic [5:0] font_char_idx,
    output logic [2:0] font_row_addr,
    input  logic [7:0] font_row_data,
    output logic       pixel_on,
    output logic       busy
);

    localparam int          c_IDX_W  = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [5:0]  c_NUM    = 6'(NUM_CHARS);
    localparam logic [5:0]  c_LAST   = 6'(NUM_CHARS - 1);
    localparam logic [10:0] c_BAND_H = 11'(MT_GLYPH_H << SCALE_SHIFT);
    localparam logic [10:0] c_SPAN   = 11'(NUM_CHARS * (MT_GLYPH_W << SCALE_SHIFT));

    // Async assert, synchronous release.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic               w_wr_ok;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [5:0]         r_slot [NUM_CHARS];

    assign w_wr_ok  = wr_en && ({1'b0, wr_addr} < c_NUM);
    assign w_wr_idx = wr_addr[c_IDX_W-1:0];

`ifdef MINI_TEXT_SHADOW_EN
    localparam bit c_FWD = 1'b0;
    logic [5:0] r_shadow [NUM_CHARS];

    // Non-blocking copy takes the pre-write shadow when a write coincides.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                r_shadow[i] <= MT_BLANK;
                r_slot[i]   <= MT_BLANK;
            end
        end else begin
            if (frame_start) r_slot <= r_shadow;
            if (w_wr_ok)     r_shadow[w_wr_idx] <= wr_data;
        end
    end
`else
    localparam bit c_FWD = 1'b1;
    logic w_unused_frame;
    assign w_unused_frame = frame_start;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++) r_slot[i] <= MT_BLANK;
        end else if (w_wr_ok) begin
            r_slot[w_wr_idx] <= wr_data;
        end
    end
`endif

    logic [10:0] w_dy;
    logic        w_in_band;
    logic [2:0]  w_row;

    assign w_dy      = {1'b0, line_y} - {1'b0, Y_POS};
    assign w_in_band = (line_y >= Y_POS) && (w_dy < c_BAND_H);
    assign w_row     = 3'(w_dy >> SCALE_SHIFT);

    mt_state_e          r_state;
    logic [c_IDX_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_line_valid;
    logic [5:0]         r_char_idx;
    logic [2:0]         r_row_addr;
    logic               r_pixel_on;

    // Code for the slot the ROM must present next cycle; a same-edge write
    // is forwarded so a not-yet-fetched slot shows its new code this line.
    logic [5:0] w_sel_pos;
    logic [5:0] w_sel_code;

    always_comb begin
        w_sel_pos  = ((r_state == FETCH) && !line_start) ? (6'(r_cnt) + 6'd1) : 6'd0;
        w_sel_code = MT_BLANK;
        if (w_sel_pos <= c_LAST) w_sel_code = r_slot[w_sel_pos[c_IDX_W-1:0]];
        if (c_FWD && w_wr_ok && ({1'b0, wr_addr} == w_sel_pos)) w_sel_code = wr_data;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_line_valid <= 1'b0;
            r_char_idx   <= 6'd0;
            r_row_addr   <= 3'd0;
        end else begin
            r_done <= 1'b0;
            if (r_done) r_line_valid <= 1'b1;
            if (line_start) begin
                r_line_valid <= 1'b0;
                r_cnt        <= '0;
                if (w_in_band) begin
                    r_state    <= FETCH;
                    r_busy     <= 1'b1;
                    r_row_addr <= w_row;
                    r_char_idx <= w_sel_code;
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end else if (r_state == FETCH) begin
                r_cnt <= r_cnt + 1'b1;
                if (6'(r_cnt) == c_LAST) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_char_idx <= w_sel_code;
                end
            end
        end
    end

    logic [10:0]        w_off;
    logic               w_hit;
    logic [c_IDX_W-1:0] w_rd_char;
    logic [2:0]         w_rd_bit;
    logic               w_buf_bit;

    assign w_off     = {1'b0, x_pixel} - {1'b0, X_POS};
    assign w_hit     = de && r_line_valid && (x_pixel >= X_POS) && (w_off < c_SPAN);
    assign w_rd_char = c_IDX_W'(w_off >> (3 + SCALE_SHIFT));
    assign w_rd_bit  = 3'd7 - 3'(w_off >> SCALE_SHIFT);

    mini_text_line_buffer #(
        .NUM_CHARS (NUM_CHARS),
        .IDX_W     (c_IDX_W)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .clr     (line_start),
        .wr_en   (r_state == FETCH),
        .wr_idx  (r_cnt),
        .wr_data (font_row_data),
        .rd_char (w_rd_char),
        .rd_bit  (w_rd_bit),
        .rd_out  (w_buf_bit)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_pixel_on <= 1'b0;
        else          r_pixel_on <= w_hit && w_buf_bit;
    end

    assign font_char_idx = r_char_idx;
    assign font_row_addr = r_row_addr;
    assign pixel_on      = r_pixel_on;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: doc/mini_text_line_engine.md
# mini_text_line_engine

Scanline text renderer for the HUD. It holds a register bank of NUM_CHARS glyph codes, fetches one glyph row per character from the shared MiniFontRom during horizontal blanking into a line buffer, and outputs a per-pixel `pixel_on` during active video. It sits between the VGA timing generator and the game-logic colour mux, and is the sole sequencer of the font ROM port.

## Interface
- NUM_CHARS, 8: characters per text line; legal range 1..32.
- X_POS, 10'd0: left pixel column of the text band.
- Y_POS, 10'd0: top pixel row of the text band.
- SCALE_SHIFT, 0: glyph magnification is 1<<SCALE_SHIFT in both axes; legal range 0..2.
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- line_start  in  1  one-cycle pulse at the start of horizontal blank.
- line_y  in  10  row number of the line that follows line_start.
- de  in  1  display enable (active video).
- x_pixel  in  10  current pixel column, valid while de=1.
- wr_en  in  1  character write strobe.
- wr_addr  in  5  character slot; writes with wr_addr >= NUM_CHARS are ignored.
- wr_data  in  6  glyph code.
- font_char_idx  out  6  to font ROM char_idx.
- font_row_addr  out  3  to font ROM row_addr.
- font_row_data  in  8  from font ROM; combinational, same cycle.
- pixel_on  out  1  text pixel lit; registered.
- busy  out  1  high while in FETCH.

## Operation
- Reset values: all char slots = 6'd63 (blank code); line buffer = 0; line_valid = 0; FSM = IDLE; pixel_on = 0; busy = 0; font_char_idx = 0; font_row_addr = 0.
- Band test: `in_band = line_y >= Y_POS && line_y < Y_POS + (8<<SCALE_SHIFT)`. Glyph row = `(line_y - Y_POS) >> SCALE_SHIFT`, truncated to 3 bits.
- FSM states:
  - IDLE: on line_start with in_band, latch the glyph row, clear the counter, clear line_valid, go to FETCH. On line_start with !in_band, clear line_valid and stay in IDLE.
  - FETCH: font_char_idx = slot[cnt] and font_row_addr = the latched row, both from registers. Each cycle, capture font_row_data into buf[cnt], then increment cnt. After slot NUM_CHARS-1 is captured, set line_valid and go to IDLE.
- Simultaneous events and boundaries:
  - line_start while in FETCH aborts the fetch and re-evaluates as from IDLE; buf contents are undefined until line_valid is set again.
  - Codes 26..63 return 0 from the ROM and render blank.
- Pixel path, with `off = x_pixel - X_POS`:
  - Lit when `de && line_valid && x_pixel >= X_POS && off < NUM_CHARS*(8<<SCALE_SHIFT)`.
  - Character = `off >> (3+SCALE_SHIFT)`; bit = `7 - ((off >> SCALE_SHIFT) & 7)`. MSB is the leftmost pixel.
- Writes: wr_en writes wr_data to slot[wr_addr] on the next edge (subject to the shadow option).

## Timing
- FETCH lasts exactly NUM_CHARS cycles. line_valid rises on the edge after the last capture, i.e. NUM_CHARS+1 cycles after line_start.
- With 25 MHz timing, horizontal blank is 160 cycles, so NUM_CHARS <= 32 always completes before de.
- pixel_on latency: 1 cycle from de/x_pixel. The timing generator must delay its colour path by 1 cycle to match.
- busy = (state == FETCH), driven from a register.
- rst_n is asserted asynchronously and released synchronously through a 2-flop synchroniser inside the block. Reset mid-fetch returns the block to reset values immediately.

## Configuration
- MINI_TEXT_SHADOW_EN defined:
  - Writes go to a shadow bank.
  - On frame_start, the shadow bank is copied into the active bank; fetch reads only the active bank, so text updates are tear-free per frame.
  - If wr_en and frame_start occur in the same cycle, the copy uses the pre-write shadow, and the write lands in the shadow only (visible from the next frame).
  - Shadow bank reset value = 6'd63.
- Undefined: a single bank is written directly. A write during FETCH to a slot not yet fetched is visible on the current line.

## Structure
- Package mini_text_pkg holds:
  - `typedef enum logic {IDLE, FETCH} mt_state_e`
  - `localparam logic [5:0] MT_BLANK = 6'd63`
  - glyph width/height constants (8).
- One sub-module, mini_text_line_buffer: NUM_CHARS x 8-bit registers with write index/data/enable, a clear input, and a combinational bit-select read (char, bit) -> 1 bit.
- The font ROM is instantiated at the top level; this block drives its address ports.

## Test plan
- Reset, then idle for 10 cycles -> pixel_on=0, busy=0, font_char_idx=0, and every slot reads back blank (nothing lit on an in-band line).
- Y_POS=100, slot0=6'd1, line_start with line_y=100 -> busy high for exactly 8 cycles, font_row_addr=0, buf[0]=8'h18. Then de with x_pixel = X_POS+3 -> pixel_on=1 one cycle later; x_pixel = X_POS+0 -> 0.
- SCALE_SHIFT=1, line_y=Y_POS+15 -> font_row_addr=7. Pixels X_POS+4 and X_POS+5 both map to glyph bit 5.
- line_start at line_y=Y_POS+8 with SCALE_SHIFT=0 (out of band) -> no FETCH, pixel_on stays 0 for the whole line.
- Second line_start 3 cycles into FETCH -> cnt restarts at 0, and busy stays high 8 more cycles.
- With MINI_TEXT_SHADOW_EN: write slot0=6'd2 mid-frame -> render still shows the old code until after frame_start; a write coinciding with frame_start appears only after the following frame_start.
